// File: rtl/word_serializer_pkg.sv
// Shared types and elaboration-time helpers for the word serializer and its FIFO.
package serializer_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int nslice(input int word_w, input int byte_w);
    return word_w / byte_w;
  endfunction

  // A single-slice word still needs a one-bit index register.
  function automatic int cnt_w(input int slices);
    return (clog2(slices) < 1) ? 1 : clog2(slices);
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Word-in / slice-out bus of the serializer; master drives words and requests.
interface word_serializer_if #(
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8
) ();
  logic [WORD_W-1:0] in_data;
  logic              in_data_ready;
  logic              in_ready;
  logic              data_request;
  logic [BYTE_W-1:0] out_data;
  logic              out_data_ready;
  logic              out_last;
  logic              empty;
  logic              overflow;
  logic              underrun;

  modport master (
    output in_data, in_data_ready, data_request,
    input  in_ready, out_data, out_data_ready, out_last, empty, overflow, underrun
  );

  modport slave (
    input  in_data, in_data_ready, data_request,
    output in_ready, out_data, out_data_ready, out_last, empty, overflow, underrun
  );
endinterface

// File: rtl/word_serializer_fifo.sv
// Single-clock word FIFO with registered occupancy count; show-ahead read port.
module word_fifo
  import serializer_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WORD_W-1:0]             din,
  output logic [WORD_W-1:0]             dout,
  output logic [clog2(FIFO_DEPTH):0]    count,
  output logic                          full,
  output logic                          empty
);
  localparam int AW = clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (!push_ok && pop_ok) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/word_serializer.sv
// Queues result words and releases them one BYTE_W slice per downstream request.
module word_serializer
  import serializer_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int BYTE_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  word_serializer_if.slave bus
);
  localparam int NSLICE = nslice(WORD_W, BYTE_W);
  localparam int CNT_W  = cnt_w(NSLICE);
  localparam int FC_W   = clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSLICE - 1);

  state_t            state;
  state_t            state_nx;
  logic [WORD_W-1:0] word_p0;
  logic [CNT_W-1:0]  idx_p0;
  logic [WORD_W-1:0] fifo_dout;
  logic [FC_W-1:0]   fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              serve;
  logic              is_last;
  logic              underrun_set;
  logic [BYTE_W-1:0] data_p1;
  logic              vld_p1;
  logic              last_p1;
  logic              overflow;
  logic              underrun;

  function automatic logic [BYTE_W-1:0] slice_of(input logic [WORD_W-1:0] word,
                                                 input logic [CNT_W-1:0]  k);
    logic [WORD_W-1:0] shifted;
    int                sh;
    sh      = MSB_FIRST ? (NSLICE - 1 - int'(k)) * BYTE_W : int'(k) * BYTE_W;
    shifted = word >> sh;
    return shifted[BYTE_W-1:0];
  endfunction

  assign push    = bus.in_data_ready && !fifo_full;
  assign is_last = (idx_p0 == LAST_IDX);

  word_fifo #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (bus.in_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // The last-slice handoff pops from the registered FIFO view, so a word
  // pushed in the same cycle is picked up later through IDLE.
  always_comb begin
    state_nx     = state;
    pop          = 1'b0;
    serve        = 1'b0;
    underrun_set = 1'b0;
    unique case (state)
      IDLE: begin
        underrun_set = bus.data_request;
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.data_request) begin
          serve = 1'b1;
          if (is_last) begin
            if (!fifo_empty) pop      = 1'b1;
            else             state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: loaded word and slice index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_p0 <= '0;
      idx_p0  <= '0;
    end else if (pop) begin
      word_p0 <= fifo_dout;
      idx_p0  <= '0;
    end else if (serve) begin
      idx_p0  <= idx_p0 + CNT_W'(1);
    end
  end

  // Stage p1: output slice, strobe and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_p1  <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      vld_p1  <= serve;
      last_p1 <= serve && is_last;
      if (serve) data_p1 <= slice_of(word_p0, idx_p0);
      if (bus.in_data_ready && fifo_full) overflow <= 1'b1;
      if (underrun_set) underrun <= 1'b1;
    end
  end

  assign bus.in_ready       = !fifo_full;
  assign bus.out_data       = data_p1;
  assign bus.out_data_ready = vld_p1;
  assign bus.out_last       = last_p1;
  assign bus.empty          = (state == IDLE) && (fifo_count == '0);
  assign bus.overflow       = overflow;
  assign bus.underrun       = underrun;
endmodule
